// File: rtl/wb_dma_pkg.sv
// Shared constants for the word-granular Wishbone block-copy sequencer.
// State encodings, bus stride, byte-lane mask and the default retry budget.
package wb_dma_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_WR_WAIT  = 3'd4;
    localparam logic [2:0] ST_FINISH   = 3'd5;

    localparam int         WORD_STRIDE   = 4;
    localparam logic [3:0] SEL_WORD      = 4'hF;
    localparam int         DEF_MAX_RETRY = 4;

endpackage

// File: rtl/wb_xfer_tracker.sv
// Access-level tracker: detects the falling edge of master activity,
// classifies the finished access and keeps the per-access retry budget.
module wb_xfer_tracker
    import wb_dma_pkg::*;
#(
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic wb_clk,
    input  logic wb_rst,
    input  logic in_wait,
    input  logic clr,
    input  logic mst_active,
    input  logic mst_err,
    input  logic mst_rty,
    output logic cmpl_ok,
    output logic cmpl_err,
    output logic cmpl_rty,
    output logic retry_exhausted
);

    localparam int RW = $clog2(MAX_RETRY + 2);

    logic          active_q;
    logic          cmpl;
    logic [RW-1:0] retry_cnt;

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= mst_active;
        end
    end

    // active_q is still low on the first wait cycle, so it cannot fire early
    assign cmpl     = in_wait & active_q & ~mst_active;
    assign cmpl_err = cmpl & mst_err;
    assign cmpl_rty = cmpl & ~mst_err & mst_rty;
    assign cmpl_ok  = cmpl & ~mst_err & ~mst_rty;

    assign retry_exhausted = (retry_cnt == RW'(MAX_RETRY));

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            retry_cnt <= '0;
        end else if (clr | cmpl_ok | cmpl_err) begin
            retry_cnt <= '0;
        end else if (cmpl_rty) begin
            if (retry_exhausted) begin
                retry_cnt <= '0;
            end else begin
                retry_cnt <= retry_cnt + RW'(1);
            end
        end
    end

endmodule

// File: rtl/wb_dma_sequencer.sv
// Block-copy controller: moves cfg_len words from cfg_src to cfg_dst
// as read-then-write pairs through a single-shot Wishbone master.
module wb_dma_sequencer
    import wb_dma_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int LEN_W     = 16,
    parameter int MAX_RETRY = DEF_MAX_RETRY
) (
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic [AW-1:0]    cfg_src,
    input  logic [AW-1:0]    cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_go,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic             mst_start,
    output logic [AW-1:0]    mst_address,
    output logic [3:0]       mst_selection,
    output logic             mst_write,
    output logic [DW-1:0]    mst_data_wr,
    input  logic             mst_active,
    input  logic [DW-1:0]    mst_data_rd,
    input  logic             mst_err,
    input  logic             mst_rty
);

    logic [2:0]       state;
    logic [AW-1:0]    cur_src;
    logic [AW-1:0]    cur_dst;
    logic [LEN_W-1:0] len;
    logic             cmpl_ok;
    logic             cmpl_err;
    logic             cmpl_rty;
    logic             retry_exhausted;
    logic             in_wait;
    logic             go_accept;

    assign in_wait   = (state == ST_RD_WAIT) | (state == ST_WR_WAIT);
    assign go_accept = (state == ST_IDLE) & cfg_go;

    wb_xfer_tracker #(
        .MAX_RETRY(MAX_RETRY)
    ) u_tracker (
        .wb_clk          (wb_clk),
        .wb_rst          (wb_rst),
        .in_wait         (in_wait),
        .clr             (go_accept),
        .mst_active      (mst_active),
        .mst_err         (mst_err),
        .mst_rty         (mst_rty),
        .cmpl_ok         (cmpl_ok),
        .cmpl_err        (cmpl_err),
        .cmpl_rty        (cmpl_rty),
        .retry_exhausted (retry_exhausted)
    );

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state         <= ST_IDLE;
            cur_src       <= '0;
            cur_dst       <= '0;
            len           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_done    <= '0;
            mst_start     <= 1'b0;
            mst_address   <= '0;
            mst_selection <= '0;
            mst_write     <= 1'b0;
            mst_data_wr   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (cfg_go) begin
                        cur_src    <= cfg_src;
                        cur_dst    <= cfg_dst;
                        len        <= cfg_len;
                        error      <= 1'b0;
                        words_done <= '0;
                        if (cfg_len == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state         <= ST_RD_ISSUE;
                            busy          <= 1'b1;
                            mst_start     <= 1'b1;
                            mst_write     <= 1'b0;
                            mst_address   <= cfg_src;
                            mst_selection <= SEL_WORD;
                        end
                    end
                end
                ST_RD_ISSUE: begin
                    mst_start <= 1'b0;
                    state     <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    unique case (1'b1)
                        cmpl_err: begin
                            error <= 1'b1;
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                        cmpl_rty: begin
                            if (retry_exhausted) begin
                                error <= 1'b1;
                                state <= ST_FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state     <= ST_RD_ISSUE;
                                mst_start <= 1'b1;
                            end
                        end
                        cmpl_ok: begin
                            state       <= ST_WR_ISSUE;
                            mst_start   <= 1'b1;
                            mst_write   <= 1'b1;
                            mst_address <= cur_dst;
                            mst_data_wr <= mst_data_rd;
                        end
                        default: ;
                    endcase
                end
                ST_WR_ISSUE: begin
                    mst_start <= 1'b0;
                    state     <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    unique case (1'b1)
                        cmpl_err: begin
                            error <= 1'b1;
                            state <= ST_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end
                        cmpl_rty: begin
                            if (retry_exhausted) begin
                                error <= 1'b1;
                                state <= ST_FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state     <= ST_WR_ISSUE;
                                mst_start <= 1'b1;
                            end
                        end
                        cmpl_ok: begin
                            words_done <= words_done + LEN_W'(1);
                            cur_src    <= cur_src + AW'(WORD_STRIDE);
                            cur_dst    <= cur_dst + AW'(WORD_STRIDE);
                            if (words_done + LEN_W'(1) == len) begin
                                state <= ST_FINISH;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state       <= ST_RD_ISSUE;
                                mst_start   <= 1'b1;
                                mst_write   <= 1'b0;
                                mst_address <= cur_src + AW'(WORD_STRIDE);
                            end
                        end
                        default: ;
                    endcase
                end
                ST_FINISH: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_dma_sequencer.sv
// Directed bench for wb_dma_sequencer with a behavioural single-shot
// master, two word RAMs and injectable rty/err responses.
module tb_wb_dma_sequencer;

    localparam int LAT = 2;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [31:0] cfg_src = '0;
    logic [31:0] cfg_dst = '0;
    logic [15:0] cfg_len = '0;
    logic        cfg_go = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_done;
    logic        mst_start;
    logic [31:0] mst_address;
    logic [3:0]  mst_selection;
    logic        mst_write;
    logic [31:0] mst_data_wr;
    logic        mst_active;
    logic [31:0] mst_data_rd;
    logic        mst_err;
    logic        mst_rty;

    wb_dma_sequencer #(
        .AW(32), .DW(32), .LEN_W(16), .MAX_RETRY(4)
    ) dut (
        .wb_clk        (wb_clk),
        .wb_rst        (wb_rst),
        .cfg_src       (cfg_src),
        .cfg_dst       (cfg_dst),
        .cfg_len       (cfg_len),
        .cfg_go        (cfg_go),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_done    (words_done),
        .mst_start     (mst_start),
        .mst_address   (mst_address),
        .mst_selection (mst_selection),
        .mst_write     (mst_write),
        .mst_data_wr   (mst_data_wr),
        .mst_active    (mst_active),
        .mst_data_rd   (mst_data_rd),
        .mst_err       (mst_err),
        .mst_rty       (mst_rty)
    );

    always #5 wb_clk = ~wb_clk;

    logic [31:0] ram0 [logic [31:0]];
    logic [31:0] ram1 [logic [31:0]];

    int compared = 0;
    int mismatched = 0;

    // fault injection knobs and bases, written only by the initial block
    int rty_rd_n = 0;
    bit rty_all = 1'b0;
    int err_wr_at = 0;
    int rd_base = 0;
    int wr_base = 0;

    // statistics, written only by the master model
    int start_total = 0;
    int done_total = 0;
    int rd_total = 0;
    int wr_total = 0;
    int rd_same = 0;

    int          lat_cnt = 0;
    logic [31:0] a_q = '0;
    logic [31:0] d_q = '0;
    logic [31:0] last_rd = 32'hFFFF_FFFF;
    logic        w_q = 1'b0;
    logic        f_err = 1'b0;
    logic        f_rty = 1'b0;

    always @(posedge wb_clk) begin
        if (mst_start === 1'b1) start_total++;
        if (done === 1'b1) done_total++;
        if (wb_rst) begin
            mst_active  <= 1'b0;
            mst_err     <= 1'b0;
            mst_rty     <= 1'b0;
            mst_data_rd <= '0;
            lat_cnt = 0;
        end else if (mst_start && !mst_active) begin
            a_q = mst_address;
            w_q = mst_write;
            d_q = mst_data_wr;
            if (w_q) begin
                wr_total++;
                f_err = (err_wr_at != 0) &&
                        (wr_total - wr_base == err_wr_at);
                f_rty = rty_all;
            end else begin
                rd_total++;
                if (a_q == last_rd) rd_same++;
                last_rd = a_q;
                f_err = 1'b0;
                f_rty = rty_all || (rd_total - rd_base <= rty_rd_n);
            end
            mst_active <= 1'b1;
            mst_err    <= 1'b0;
            mst_rty    <= 1'b0;
            lat_cnt = LAT - 1;
        end else if (mst_active) begin
            if (lat_cnt == 0) begin
                mst_active <= 1'b0;
                mst_err    <= f_err;
                mst_rty    <= f_rty;
                if (!w_q) begin
                    mst_data_rd <= ram0.exists(a_q) ? ram0[a_q] : 32'h0;
                end else if (!f_err && !f_rty) begin
                    ram1[a_q] = d_q;
                end
            end else begin
                lat_cnt--;
            end
        end
    end

    task automatic go(input logic [31:0] s, input logic [31:0] d,
                      input logic [15:0] n);
        @(negedge wb_clk);
        cfg_src = s;
        cfg_dst = d;
        cfg_len = n;
        cfg_go  = 1'b1;
        @(negedge wb_clk);
        cfg_go  = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (cyc < max) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge wb_clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge wb_clk);
        compared++;
        if ({busy, done, error, mst_start, mst_write} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy, done, error, mst_start, mst_write});
        end
        compared++;
        if ({words_done, mst_selection} !== 20'h0) begin
            mismatched++;
            $display("FAIL reset_counts: got %h expected 0",
                     {words_done, mst_selection});
        end
        compared++;
        if ({mst_address, mst_data_wr} !== 64'h0) begin
            mismatched++;
            $display("FAIL reset_bus: got %h expected 0",
                     {mst_address, mst_data_wr});
        end
        wb_rst = 1'b0;
    endtask

    task automatic test_copy4();
        int s0, d0, cyc;
        bit ok;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h11111111;
        exp_w[1] = 32'h22222222;
        exp_w[2] = 32'h33333333;
        exp_w[3] = 32'h44444444;
        s0 = start_total;
        d0 = done_total;
        go(32'h2000_0000, 32'h3000_0000, 16'd4);
        wait_done(400, cyc, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL copy4_timeout: got no done expected done");
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (ram1[32'h3000_0000 + 32'(4 * i)] !== exp_w[i]) begin
                mismatched++;
                $display("FAIL copy4_word%0d: got %h expected %h", i,
                         ram1[32'h3000_0000 + 32'(4 * i)], exp_w[i]);
            end
        end
        compared++;
        if (words_done !== 16'd4 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL copy4_status: got wd=%0d err=%b expected 4/0",
                     words_done, error);
        end
        repeat (3) @(negedge wb_clk);
        compared++;
        if (done_total - d0 != 1 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL copy4_done: got %0d pulses expected 1",
                     done_total - d0);
        end
        compared++;
        if (start_total - s0 != 8) begin
            mismatched++;
            $display("FAIL copy4_starts: got %0d expected 8",
                     start_total - s0);
        end
    endtask

    task automatic test_len0();
        int s0, d0, cyc;
        bit ok;
        s0 = start_total;
        d0 = done_total;
        go(32'h2000_0000, 32'h3000_0100, 16'd0);
        wait_done(3, cyc, ok);
        compared++;
        if (!ok || cyc > 1) begin
            mismatched++;
            $display("FAIL len0_done: got ok=%b cyc=%0d expected done<=2",
                     ok, cyc);
        end
        compared++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL len0_flags: got busy=%b err=%b expected 0/0",
                     busy, error);
        end
        repeat (3) @(negedge wb_clk);
        compared++;
        if (start_total != s0 || done_total - d0 != 1) begin
            mismatched++;
            $display("FAIL len0_bus: got starts=%0d dones=%0d expected 0/1",
                     start_total - s0, done_total - d0);
        end
    endtask

    task automatic test_retry_ok();
        int cyc, rs0;
        bit ok;
        ram0[32'h2000_0010] = 32'hA5A5_0003;
        rd_base = rd_total;
        wr_base = wr_total;
        rs0 = rd_same;
        rty_rd_n = 2;
        go(32'h2000_0010, 32'h3000_0200, 16'd1);
        wait_done(400, cyc, ok);
        rty_rd_n = 0;
        compared++;
        if (!ok || rd_total - rd_base != 3 || wr_total - wr_base != 1) begin
            mismatched++;
            $display("FAIL retry_issues: got rd=%0d wr=%0d expected 3/1",
                     rd_total - rd_base, wr_total - wr_base);
        end
        compared++;
        if (rd_same - rs0 != 2) begin
            mismatched++;
            $display("FAIL retry_addr: got %0d repeats expected 2",
                     rd_same - rs0);
        end
        compared++;
        if (ram1[32'h3000_0200] !== 32'hA5A5_0003 || error !== 1'b0) begin
            mismatched++;
            $display("FAIL retry_data: got %h err=%b expected a5a50003/0",
                     ram1[32'h3000_0200], error);
        end
    endtask

    task automatic test_retry_abort();
        int s0, cyc;
        bit ok;
        s0 = start_total;
        rty_all = 1'b1;
        go(32'h2000_0000, 32'h3000_0300, 16'd1);
        wait_done(400, cyc, ok);
        rty_all = 1'b0;
        compared++;
        if (!ok || start_total - s0 != 5) begin
            mismatched++;
            $display("FAIL abort_issues: got %0d ok=%b expected 5",
                     start_total - s0, ok);
        end
        compared++;
        if (error !== 1'b1 || words_done !== 16'd0) begin
            mismatched++;
            $display("FAIL abort_status: got err=%b wd=%0d expected 1/0",
                     error, words_done);
        end
        compared++;
        if (ram1.exists(32'h3000_0300)) begin
            mismatched++;
            $display("FAIL abort_ram: got written expected untouched");
        end
    endtask

    task automatic test_err_write();
        int cyc;
        bit ok;
        wr_base = wr_total;
        err_wr_at = 2;
        go(32'h2000_0000, 32'h3000_0400, 16'd3);
        wait_done(400, cyc, ok);
        err_wr_at = 0;
        compared++;
        if (!ok || words_done !== 16'd1 || error !== 1'b1) begin
            mismatched++;
            $display("FAIL err_status: got wd=%0d err=%b expected 1/1",
                     words_done, error);
        end
        compared++;
        if (ram1[32'h3000_0400] !== 32'h11111111 ||
            ram1.exists(32'h3000_0404)) begin
            mismatched++;
            $display("FAIL err_ram: got %h expected 11111111 only",
                     ram1[32'h3000_0400]);
        end
        go(32'h2000_0000, 32'h3000_0400, 16'd3);
        compared++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL err_clear: got err=%b busy=%b expected 0/1",
                     error, busy);
        end
        wait_done(400, cyc, ok);
        compared++;
        if (!ok || words_done !== 16'd3 || error !== 1'b0 ||
            ram1[32'h3000_0408] !== 32'h33333333) begin
            mismatched++;
            $display("FAIL err_rerun: got wd=%0d err=%b w2=%h expected 3/0/33333333",
                     words_done, error, ram1[32'h3000_0408]);
        end
    endtask

    task automatic test_back_to_back();
        int s0, cyc;
        bit ok;
        s0 = start_total;
        go(32'h2000_0000, 32'h3000_0500, 16'd2);
        repeat (5) @(negedge wb_clk);
        go(32'h2000_0008, 32'h3000_0600, 16'd1);
        wait_done(400, cyc, ok);
        compared++;
        if (!ok || words_done !== 16'd2 || start_total - s0 != 4) begin
            mismatched++;
            $display("FAIL busy_go_status: got wd=%0d starts=%0d expected 2/4",
                     words_done, start_total - s0);
        end
        compared++;
        if (ram1[32'h3000_0500] !== 32'h11111111 ||
            ram1[32'h3000_0504] !== 32'h22222222 ||
            ram1.exists(32'h3000_0600)) begin
            mismatched++;
            $display("FAIL busy_go_ram: got %h %h expected 11111111 22222222",
                     ram1[32'h3000_0500], ram1[32'h3000_0504]);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit ok;
        go(32'h2000_0000, 32'h3000_0700, 16'd4);
        cyc = 0;
        while (!(mst_active === 1'b1 && mst_write === 1'b0) && cyc < 20) begin
            @(negedge wb_clk);
            cyc++;
        end
        compared++;
        if (cyc >= 20) begin
            mismatched++;
            $display("FAIL rst_mid_wait: got no read expected read");
        end
        wb_rst = 1'b1;
        @(negedge wb_clk);
        compared++;
        if (busy !== 1'b0 || mst_start !== 1'b0 || words_done !== 16'd0 ||
            done !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_out: got busy=%b start=%b wd=%0d expected 0/0/0",
                     busy, mst_start, words_done);
        end
        wb_rst = 1'b0;
        go(32'h2000_000C, 32'h3000_0800, 16'd1);
        wait_done(400, cyc, ok);
        compared++;
        if (!ok || ram1[32'h3000_0800] !== 32'h44444444 ||
            ram1.exists(32'h3000_0700)) begin
            mismatched++;
            $display("FAIL rst_mid_idle: got %h expected 44444444",
                     ram1[32'h3000_0800]);
        end
    endtask

    initial begin
        ram0[32'h2000_0000] = 32'h11111111;
        ram0[32'h2000_0004] = 32'h22222222;
        ram0[32'h2000_0008] = 32'h33333333;
        ram0[32'h2000_000C] = 32'h44444444;
        test_reset();
        test_copy4();
        test_len0();
        test_retry_ok();
        test_retry_abort();
        test_err_write();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary expected finish");
        $fatal(1, "watchdog");
    end

endmodule
